// File: rtl/period_meter_pkg.sv
// period_meter_pkg: shared types and default parameter values for the
// period meter.
//   state_t          - measurement FSM state encoding
//   DEF_CNT_WIDTH    - default width of the period/high-time counters
//   DEF_SYNC_STAGES  - default synchronizer depth
//   DEF_TIMEOUT_CYC  - default stall timeout in clock cycles
package period_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int DEF_CNT_WIDTH   = 32'sd16;
  localparam int DEF_SYNC_STAGES = 32'sd2;
  localparam int DEF_TIMEOUT_CYC = 32'sd50000;

endpackage

// File: rtl/period_meter_sync_edge.sv
// sync_edge: brings an asynchronous input into the clk domain and reports
// single-cycle rise/fall pulses.
// Ports:
//   clk, rst  - clock and asynchronous active-high reset
//   sig_in    - asynchronous input
//   rise      - synchronized level went 0 -> 1 (combinational from flops)
//   fall      - synchronized level went 1 -> 0 (combinational from flops)
module sync_edge
  import period_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   hist;
  // Shift chain of ones marking when sync_ff and hist hold real samples.
  // Edges are suppressed until then, so a level already high at reset
  // release is not mistaken for a rise.
  logic [SYNC_STAGES:0]   fill;

  // Synchronizer chain, history flop and fill marker.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_ff <= '0;
      hist    <= 1'b0;
      fill    <= '0;
    end else begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], sig_in};
      hist    <= sync_ff[SYNC_STAGES-1];
      fill    <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign rise = fill[SYNC_STAGES] &  sync_ff[SYNC_STAGES-1] & ~hist;
  assign fall = fill[SYNC_STAGES] & ~sync_ff[SYNC_STAGES-1] &  hist;

endmodule

// File: rtl/period_meter.sv
// period_meter: measures the period and high time of an asynchronous
// signal in clk cycles and holds each result for a consumer handshake.
// Ports:
//   clk, rst   - clock and asynchronous active-high reset
//   sig_in     - asynchronous signal under measurement
//   ack        - consumer acknowledge of the held result
//   period     - cycles between two consecutive rising edges
//   high_time  - cycles from a rising edge to the following falling edge
//   valid      - period/high_time hold a fresh, unacknowledged result
//   overrun    - sticky: a result was dropped while valid was high
//   stall      - no rising edge seen for TIMEOUT_CYC cycles
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sig_in,
  input  logic                 ack,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 overrun,
  output logic                 stall
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT = CNT_WIDTH'(TIMEOUT_CYC);
  localparam logic [CNT_WIDTH-1:0] ONE     = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic                 rise;
  logic                 fall;
  state_t               state;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_next;
  logic [CNT_WIDTH-1:0] hi_cnt;
  logic [CNT_WIDTH-1:0] hi_next;
  logic                 stall_next;
  logic                 capture;

  sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .sig_in(sig_in),
    .rise  (rise),
    .fall  (fall)
  );

  // FSM state, cycle counter, high-time latch and stall flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      hi_cnt <= '0;
      stall  <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      hi_cnt <= hi_next;
      stall  <= stall_next;
    end
  end

  // Next-state logic: counting, high-time capture, timeout and capture strobe.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    hi_next    = hi_cnt;
    stall_next = stall;
    capture    = 1'b0;
    case (state)
      IDLE: begin
        // The rise leaving IDLE only starts a period; it yields no result.
        if (rise) begin
          state_next = FIRST;
          cnt_next   = ONE;
          stall_next = 1'b0;
        end else begin
          state_next = IDLE;
        end
      end
      FIRST, MEASURE: begin
        if (fall) begin
          hi_next = cnt;
        end else begin
          hi_next = hi_cnt;
        end
        if (rise) begin
          capture    = 1'b1;
          state_next = MEASURE;
          cnt_next   = ONE;
        end else if (cnt == TIMEOUT) begin
          // cnt is left at TIMEOUT, so it can never wrap.
          state_next = IDLE;
          stall_next = 1'b1;
        end else begin
          cnt_next = cnt + ONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Result holding register with valid/ack handshake and sticky overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
    end else if (capture) begin
      if (valid && !ack) begin
        // Consumer has not taken the old result: drop the new one.
        overrun <= 1'b1;
      end else begin
        // Either empty, or acked on this very edge: load and stay valid.
        period    <= cnt;
        high_time <= hi_cnt;
        valid     <= 1'b1;
        if (valid) begin
          overrun <= 1'b0;
        end else begin
          overrun <= overrun;
        end
      end
    end else if (valid && ack) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      valid   <= valid;
      overrun <= overrun;
    end
  end

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: directed self-checking bench for period_meter
// (CNT_WIDTH=16, SYNC_STAGES=2, TIMEOUT_CYC=100).
module tb_period_meter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sig_in = 1'b0;
  logic        ack = 1'b0;
  logic [15:0] period;
  logic [15:0] high_time;
  logic        valid;
  logic        overrun;
  logic        stall;

  int          checks = 0;
  int          errors = 0;
  int          n_res = 0;
  logic [15:0] last_p = 16'd0;
  logic [15:0] last_h = 16'd0;
  logic        valid_q = 1'b0;
  logic        auto_ack = 1'b0;
  logic        ack_req = 1'b0;

  always #5 clk = ~clk;

  period_meter #(
    .CNT_WIDTH  (16),
    .SYNC_STAGES(2),
    .TIMEOUT_CYC(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sig_in   (sig_in),
    .ack      (ack),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .overrun  (overrun),
    .stall    (stall)
  );

  // One clock cycle: drive inputs, pass the edge, sample 1 time unit later.
  task automatic tick(input logic s);
    sig_in = s;
    ack    = ack_req | (auto_ack & valid);
    @(posedge clk);
    #1;
    if (valid && !valid_q) begin
      n_res++;
      last_p = period;
      last_h = high_time;
    end
    valid_q = valid;
  endtask

  task automatic drive_period(input int hi, input int lo);
    for (int i = 0; i < hi; i++) tick(1'b1);
    for (int i = 0; i < lo; i++) tick(1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; sig_in = 1'b0; ack = 1'b0; ack_req = 1'b0; auto_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_res = 0; valid_q = 1'b0; last_p = 16'd0; last_h = 16'd0;
    repeat (5) tick(1'b0);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    sig_in = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
    checks++; if (high_time !== 16'd0) begin errors++; $display("FAIL reset_high: got %0d want 0", high_time); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %0b want 0", overrun); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
    // Release with the input already high: that level must not start a period.
    rst = 1'b0;
    repeat (10) tick(1'b1);
    repeat (12) tick(1'b0);
    drive_period(12, 12);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_level_rise: valid got %0b want 0", valid); end
    repeat (3) tick(1'b1);
    checks++; if (n_res !== 1) begin errors++; $display("FAIL reset_first_result: count got %0d want 1", n_res); end
    checks++; if (last_p !== 16'd24) begin errors++; $display("FAIL reset_first_period: got %0d want 24", last_p); end
  endtask

  task automatic test_latency();
    do_reset();
    drive_period(12, 12);
    tick(1'b1); tick(1'b1);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL latency_early: valid got %0b want 0", valid); end
    tick(1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL latency_edge: valid got %0b want 1", valid); end
    checks++; if (period !== 16'd24) begin errors++; $display("FAIL latency_period: got %0d want 24", period); end
    checks++; if (high_time !== 16'd12) begin errors++; $display("FAIL latency_high: got %0d want 12", high_time); end
  endtask

  task automatic test_square();
    do_reset();
    auto_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_period(12, 12);
      if (i > 0) begin
        checks++; if (n_res !== i) begin errors++; $display("FAIL square_count: got %0d want %0d", n_res, i); end
        checks++; if (last_p !== 16'd24) begin errors++; $display("FAIL square_period: got %0d want 24", last_p); end
        checks++; if (last_h !== 16'd12) begin errors++; $display("FAIL square_high: got %0d want 12", last_h); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL square_overrun: got %0b want 0", overrun); end
      end
    end
    auto_ack = 1'b0;
  endtask

  task automatic test_overrun();
    do_reset();
    drive_period(12, 12);
    drive_period(5, 15);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid1: got %0b want 1", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre: got %0b want 0", overrun); end
    drive_period(12, 12);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %0b want 1", overrun); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL ovr_valid2: got %0b want 1", valid); end
    checks++; if (period !== 16'd24) begin errors++; $display("FAIL ovr_kept_period: got %0d want 24", period); end
    checks++; if (high_time !== 16'd12) begin errors++; $display("FAIL ovr_kept_high: got %0d want 12", high_time); end
    ack_req = 1'b1;
    tick(1'b0);
    ack_req = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL ovr_ack_valid: got %0b want 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear: got %0b want 0", overrun); end
  endtask

  task automatic test_ack_same_edge();
    do_reset();
    drive_period(12, 12);
    drive_period(8, 8);
    checks++; if (period !== 16'd24) begin errors++; $display("FAIL same_pre_period: got %0d want 24", period); end
    tick(1'b1); tick(1'b1);
    ack_req = 1'b1;
    tick(1'b1);
    ack_req = 1'b0;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %0b want 1", valid); end
    checks++; if (period !== 16'd16) begin errors++; $display("FAIL same_period: got %0d want 16", period); end
    checks++; if (high_time !== 16'd8) begin errors++; $display("FAIL same_high: got %0d want 8", high_time); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL same_overrun: got %0b want 0", overrun); end
    tick(1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL same_hold: got %0b want 1", valid); end
  endtask

  task automatic test_timeout();
    int base;
    do_reset();
    auto_ack = 1'b1;
    drive_period(12, 12);
    for (int j = 0; j < 103; j++) begin
      tick((j < 12) ? 1'b1 : 1'b0);
      if (j == 101) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_early: got %0b want 0", stall); end
      end
      if (j == 102) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_set: got %0b want 1", stall); end
      end
    end
    checks++; if (n_res !== 1) begin errors++; $display("FAIL stall_results: got %0d want 1", n_res); end
    repeat (5) tick(1'b0);
    base = n_res;
    for (int j = 0; j < 3; j++) begin
      tick(1'b1);
      if (j == 1) begin
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_hold: got %0b want 1", stall); end
      end
      if (j == 2) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_clear: got %0b want 0", stall); end
      end
    end
    checks++; if (n_res !== base) begin errors++; $display("FAIL restart_no_result: got %0d want %0d", n_res, base); end
    drive_period(9, 12);
    repeat (3) tick(1'b1);
    checks++; if (n_res !== base + 1) begin errors++; $display("FAIL restart_result: got %0d want %0d", n_res, base + 1); end
    checks++; if (last_p !== 16'd24) begin errors++; $display("FAIL restart_period: got %0d want 24", last_p); end
    checks++; if (last_h !== 16'd12) begin errors++; $display("FAIL restart_high: got %0d want 12", last_h); end
    auto_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive_period(12, 12);
    drive_period(12, 12);
    repeat (5) tick(1'b1);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL mid_pre_overrun: got %0b want 1", overrun); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (period !== 16'd0) begin errors++; $display("FAIL mid_period: got %0d want 0", period); end
    checks++; if (high_time !== 16'd0) begin errors++; $display("FAIL mid_high: got %0d want 0", high_time); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_overrun: got %0b want 0", overrun); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %0b want 0", stall); end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; valid_q = 1'b0; n_res = 0;
    repeat (4) tick(1'b1);
    repeat (12) tick(1'b0);
    drive_period(12, 12);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL mid_one_rise: valid got %0b want 0", valid); end
    repeat (3) tick(1'b1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL mid_two_rise: valid got %0b want 1", valid); end
    checks++; if (period !== 16'd24) begin errors++; $display("FAIL mid_new_period: got %0d want 24", period); end
  endtask

  task automatic test_duty();
    do_reset();
    auto_ack = 1'b1;
    for (int h = 1; h <= 9; h++) begin
      drive_period(h, 10 - h);
      if (h > 1) begin
        checks++; if (last_h !== 16'(h - 1)) begin errors++; $display("FAIL duty_high: got %0d want %0d", last_h, h - 1); end
        checks++; if (last_p !== 16'd10) begin errors++; $display("FAIL duty_period: got %0d want 10", last_p); end
      end
    end
    repeat (3) tick(1'b1);
    checks++; if (last_h !== 16'd9) begin errors++; $display("FAIL duty_high_last: got %0d want 9", last_h); end
    checks++; if (last_p !== 16'd10) begin errors++; $display("FAIL duty_period_last: got %0d want 10", last_p); end
    auto_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_latency();
    test_square();
    test_overrun();
    test_ack_same_edge();
    test_timeout();
    test_reset_mid();
    test_duty();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the period and high-time results.
REQ-002 Parameter SYNC_STAGES, default 2: flip-flop stages in the input synchronizer, minimum 2.
REQ-003 Parameter TIMEOUT_CYC, default 50000: cycles without a rising edge before a stall is declared; SHALL be at most 2^CNT_WIDTH-1.
REQ-004 CLK  input  1  single system clock; all state SHALL be clocked on its rising edge.
REQ-005 RST  input  1  reset, asynchronous, active-high.
REQ-006 SIG_IN  input  1  asynchronous signal under measurement, for example a divided clock.
REQ-007 ACK  input  1  consumer acknowledge for the held result.
REQ-008 PERIOD  output  CNT_WIDTH  CLK cycles between two consecutive rising edges of SIG_IN.
REQ-009 HIGH_TIME  output  CNT_WIDTH  CLK cycles from a rising edge to the following falling edge.
REQ-010 VALID  output  1  PERIOD and HIGH_TIME hold a fresh, unacknowledged result.
REQ-011 OVERRUN  output  1  sticky flag: a result was discarded while VALID was high.
REQ-012 STALL  output  1  no rising edge was seen for TIMEOUT_CYC cycles.

Function
REQ-013 SIG_IN SHALL pass through SYNC_STAGES flip-flops and one history flop; rise = sync & ~hist, fall = ~sync & hist.
REQ-014 FSM states SHALL be IDLE, FIRST and MEASURE.
- IDLE: waits for a rise, then goes to FIRST with cnt <= 1.
- FIRST: cnt increments; a fall captures hi_cnt <= cnt; a rise captures a result and goes to MEASURE.
- MEASURE: same behaviour as FIRST.
REQ-015 In FIRST and MEASURE, every rise SHALL set cnt <= 1; every other cycle SHALL set cnt <= cnt+1.
REQ-016 On a rise in FIRST or MEASURE, the block SHALL capture PERIOD <= cnt and HIGH_TIME <= hi_cnt; no result SHALL be produced for the rise that leaves IDLE.
REQ-017 VALID SHALL rise on the CLK edge that captures the result, which is SYNC_STAGES+1 CLK edges after the first edge sampling SIG_IN high.
REQ-018 VALID, PERIOD and HIGH_TIME SHALL hold until ACK is sampled high while VALID=1; VALID then clears on that edge.
REQ-019 ACK while VALID=0 SHALL be ignored.
REQ-020 ACK and a new capture on the same edge: the new result SHALL load, VALID SHALL stay 1, and OVERRUN SHALL not set.
REQ-021 New capture while VALID=1 without ACK: the new result SHALL be discarded, the old result kept, and OVERRUN set to 1.
REQ-022 OVERRUN SHALL clear only on an edge where ACK=1 and VALID=1 and no new discard occurs.
REQ-023 When cnt reaches TIMEOUT_CYC in FIRST or MEASURE, the FSM SHALL enter IDLE, set STALL=1, and leave cnt at TIMEOUT_CYC; no result is produced.
REQ-024 STALL SHALL clear on the next rise, which also starts FIRST.
REQ-025 A fall not preceded by a rise in the current period SHALL leave hi_cnt unchanged.
REQ-026 The counter SHALL never wrap, because TIMEOUT_CYC < 2^CNT_WIDTH bounds it.

Reset
REQ-027 RST=1 SHALL asynchronously force:
- state to IDLE;
- cnt, hi_cnt, PERIOD and HIGH_TIME to 0;
- VALID, OVERRUN and STALL to 0;
- all synchronizer and history flops to 0.
REQ-028 Reset deassertion mid-measurement SHALL restart from IDLE, with no partial result emitted.
REQ-029 A SIG_IN level of 1 at reset release SHALL not count as a rise.

Structure
REQ-030 Package period_meter_pkg SHALL hold the state enum type and the default parameter constants.
REQ-031 Sub-module sync_edge SHALL contain the synchronizer, history flop and rise/fall outputs, parameterised by SYNC_STAGES.
REQ-032 The target size is 120-400 lines of RTL in total.

Verification
REQ-033 Square wave, 24-cycle period, 12 high (a divide-by-12 toggle), ACK pulsed each result -> 2nd and later results PERIOD=24, HIGH_TIME=12, VALID 1 each period, OVERRUN=0.
REQ-034 Same source with ACK held 0 -> first result kept (24/12), VALID stays 1, OVERRUN=1 at the next capture; one ACK then clears VALID and OVERRUN.
REQ-035 ACK asserted on the exact edge a new capture occurs -> VALID remains 1, new value loaded, OVERRUN stays 0.
REQ-036 TIMEOUT_CYC=100, SIG_IN stops after one period -> STALL=1 exactly 100 cycles after the last rise, state IDLE; restarting the wave -> STALL clears at the first rise, first result one period later.
REQ-037 RST pulsed mid-period with VALID=1 -> all outputs 0 immediately; the next result appears only after two post-reset rises.
REQ-038 Duty-cycle sweep, period 10 with high 1..9 -> HIGH_TIME tracks 1..9 and PERIOD=10 throughout.
